beam_scan_ctrl: RTL and testbench

BEAM_SCAN_CTRL -- requirements
Module: beam_scan_ctrl

---
 rtl/beam_pkg.sv | 26 ++
 rtl/beam_scan_ctrl_if.sv | 24 ++
 rtl/scan_coord_gen.sv | 52 +++++
 rtl/beam_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_beam_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/beam_pkg.sv
// rtl/beam_pkg.sv - shared state encoding, coordinate width and default scan grid
package beam_pkg;

   localparam int COORD_W = 16;

   typedef logic [COORD_W-1:0] coord_t;

   localparam int     DEF_NUM_X   = 8;
   localparam int     DEF_NUM_Z   = 32;
   localparam coord_t DEF_X_START = 16'h0000;
   localparam coord_t DEF_Z_START = 16'h0100;
   localparam coord_t DEF_X_STEP  = 16'h0010;
   localparam coord_t DEF_Z_STEP  = 16'h0008;
   localparam int     DEF_TIMEOUT = 1024;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_WAIT_RDY,
      S_EMIT,
      S_ADVANCE,
      S_FINISH
   } scan_state_t;

endpackage

// File: rtl/beam_scan_ctrl_if.sv
// rtl/beam_scan_ctrl_if.sv - datapath control and focal point handshake bundle
interface beam_scan_ctrl_if;
   import beam_pkg::*;

   logic   dc_clear;
   logic   dc_start;
   logic   dc_ready;
   coord_t x_f;
   coord_t z_f;
   logic   pt_valid;
   logic   pt_ready;
   logic   pt_last;

   modport master (
      output dc_clear, dc_start, x_f, z_f, pt_valid, pt_last,
      input  dc_ready, pt_ready
   );

   modport slave (
      input  dc_clear, dc_start, x_f, z_f, pt_valid, pt_last,
      output dc_ready, pt_ready
   );

endinterface

// File: rtl/scan_coord_gen.sv
// rtl/scan_coord_gen.sv - raster index counters and focal coordinate accumulators
module scan_coord_gen
   import beam_pkg::*;
#(
   parameter int     NUM_X   = DEF_NUM_X,
   parameter int     NUM_Z   = DEF_NUM_Z,
   parameter coord_t X_START = DEF_X_START,
   parameter coord_t Z_START = DEF_Z_START,
   parameter coord_t X_STEP  = DEF_X_STEP,
   parameter coord_t Z_STEP  = DEF_Z_STEP
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   load,
   input  logic   advance,
   output coord_t x_f,
   output coord_t z_f,
   output logic   last_pt
);

   localparam int XW = (NUM_X > 1) ? $clog2(NUM_X) : 1;
   localparam int ZW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(NUM_X - 1);
   localparam logic [ZW-1:0] Z_LAST = ZW'(NUM_Z - 1);

   logic [XW-1:0] x_idx;
   logic [ZW-1:0] z_idx;

   // Indices are tracked separately so coordinate wrap never disturbs raster position.
   assign last_pt = (x_idx == X_LAST) && (z_idx == Z_LAST);

   // Depth is the inner loop; a depth rollover steps the lateral column. Last point holds.
   always_ff @(posedge clk) begin
      if (reset || load) begin
         x_idx <= '0;
         z_idx <= '0;
         x_f   <= X_START;
         z_f   <= Z_START;
      end else if (advance && !last_pt) begin
         if (z_idx != Z_LAST) begin
            z_idx <= z_idx + ZW'(1);
            z_f   <= z_f + Z_STEP;
         end else begin
            z_idx <= '0;
            z_f   <= Z_START;
            x_idx <= x_idx + XW'(1);
            x_f   <= x_f + X_STEP;
         end
      end
   end

endmodule

// File: rtl/beam_scan_ctrl.sv
// rtl/beam_scan_ctrl.sv - full-frame focal point sequencer for the delay/focus datapath
module beam_scan_ctrl
   import beam_pkg::*;
#(
   parameter int     NUM_X   = DEF_NUM_X,
   parameter int     NUM_Z   = DEF_NUM_Z,
   parameter coord_t X_START = DEF_X_START,
   parameter coord_t Z_START = DEF_Z_START,
   parameter coord_t X_STEP  = DEF_X_STEP,
   parameter coord_t Z_STEP  = DEF_Z_STEP,
   parameter int     TIMEOUT = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                scan_start,
   input  logic                scan_abort,
   beam_scan_ctrl_if.master    bus,
   output logic                busy,
   output logic                done,
   output logic                timeout_err,
   output logic [COORD_W-1:0]  point_count
);

   localparam int TW = $clog2(TIMEOUT + 1);

   scan_state_t   state;
   scan_state_t   state_nxt;
   logic [TW-1:0] wait_cnt;
   logic          clr_pulse_q;
   logic          load;
   logic          advance;
   logic          last_pt;
   logic          abort_hit;
   logic          tmo_hit;
   coord_t        x_cur;
   coord_t        z_cur;

   scan_coord_gen #(
      .NUM_X   (NUM_X),
      .NUM_Z   (NUM_Z),
      .X_START (X_START),
      .Z_START (Z_START),
      .X_STEP  (X_STEP),
      .Z_STEP  (Z_STEP)
   ) u_coord (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .advance (advance),
      .x_f     (x_cur),
      .z_f     (z_cur),
      .last_pt (last_pt)
   );

   // Abort wins over everything; the timeout fires when the next count would hit TIMEOUT-1.
   assign abort_hit = scan_abort && (state != S_IDLE);
   assign tmo_hit   = (state == S_WAIT_RDY) && !bus.dc_ready &&
                      ((wait_cnt + TW'(1)) == TW'(TIMEOUT - 1));

   // Next-state decode with abort overriding any other transition.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      advance   = 1'b0;
      case (state)
         S_IDLE: begin
            if (scan_start) begin
               load      = 1'b1;
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR:    state_nxt = S_START;
         S_START:    state_nxt = S_WAIT_RDY;
         S_WAIT_RDY: begin
            if (bus.dc_ready) begin
               state_nxt = S_EMIT;
            end else if (tmo_hit) begin
               state_nxt = S_IDLE;
            end
         end
         S_EMIT: begin
            if (bus.pt_ready) begin
               state_nxt = S_ADVANCE;
            end
         end
         S_ADVANCE: begin
            advance   = 1'b1;
            state_nxt = last_pt ? S_FINISH : S_CLEAR;
         end
         S_FINISH:   state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
      if (abort_hit) begin
         state_nxt = S_IDLE;
         advance   = 1'b0;
      end
   end

   // State register plus the trailing clear pulse after an abort or timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         clr_pulse_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         clr_pulse_q <= abort_hit || tmo_hit;
      end
   end

   // Ready-wait counter restarts on every datapath start.
   always_ff @(posedge clk) begin
      if (reset || state == S_START) begin
         wait_cnt <= '0;
      end else if (state == S_WAIT_RDY) begin
         wait_cnt <= wait_cnt + TW'(1);
      end
   end

   // Sticky timeout flag and per-frame point counter, both cleared by an accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_err <= 1'b0;
         point_count <= '0;
      end else if (load) begin
         timeout_err <= 1'b0;
         point_count <= '0;
      end else begin
         if (tmo_hit && !abort_hit) begin
            timeout_err <= 1'b1;
         end
         if (advance) begin
            point_count <= point_count + COORD_W'(1);
         end
      end
   end

   assign bus.dc_clear = reset || (state == S_CLEAR) || (state == S_FINISH) || clr_pulse_q;
   assign bus.dc_start = (state == S_START);
   assign bus.pt_valid = (state == S_EMIT);
   assign bus.pt_last  = (state == S_EMIT) && last_pt;
   assign bus.x_f      = x_cur;
   assign bus.z_f      = z_cur;
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_FINISH);

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// tb/tb_beam_scan_ctrl.sv - scoreboard bench for the beam scan controller
module tb_beam_scan_ctrl;

   typedef struct {
      logic [15:0] x;
      logic [15:0] z;
      logic        last;
   } pt_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        scan_start;
   logic        scan_start_b;
   logic        scan_abort;
   logic        pt_ready;
   logic        dp_en;
   logic        busy_a, done_a, tmo_a;
   logic        busy_b, done_b, tmo_b;
   logic [15:0] pc_a, pc_b;

   int checks = 0;
   int errors = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   int dly_a = 0;
   int dly_b = 0;

   pt_t q_a[$];
   pt_t q_b[$];

   logic [15:0] ax_tab [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 16'h0010};
   logic [15:0] bx_tab [6] = '{16'hFFF0, 16'hFFF0, 16'hFFF0, 16'h0010, 16'h0010, 16'h0010};
   logic [15:0] z_tab  [6] = '{16'h0100, 16'h0108, 16'h0110, 16'h0100, 16'h0108, 16'h0110};

   always #5 clk = ~clk;

   beam_scan_ctrl_if bus_a ();
   beam_scan_ctrl_if bus_b ();

   beam_scan_ctrl #(
      .NUM_X(2), .NUM_Z(3), .X_START(16'h0000), .Z_START(16'h0100),
      .X_STEP(16'h0010), .Z_STEP(16'h0008), .TIMEOUT(16)
   ) dut_a (
      .clk(clk), .reset(reset), .scan_start(scan_start), .scan_abort(scan_abort),
      .bus(bus_a), .busy(busy_a), .done(done_a), .timeout_err(tmo_a), .point_count(pc_a)
   );

   beam_scan_ctrl #(
      .NUM_X(2), .NUM_Z(3), .X_START(16'hFFF0), .Z_START(16'h0100),
      .X_STEP(16'h0020), .Z_STEP(16'h0008), .TIMEOUT(16)
   ) dut_b (
      .clk(clk), .reset(reset), .scan_start(scan_start_b), .scan_abort(scan_abort),
      .bus(bus_b), .busy(busy_b), .done(done_b), .timeout_err(tmo_b), .point_count(pc_b)
   );

   // Datapath models: ready pulses 5 cycles after dc_start.
   always @(posedge clk) begin
      if (bus_a.dc_start) dly_a <= 5;
      else if (dly_a != 0) dly_a <= dly_a - 1;
      if (bus_b.dc_start) dly_b <= 5;
      else if (dly_b != 0) dly_b <= dly_b - 1;
   end

   assign bus_a.dc_ready = dp_en && (dly_a == 1);
   assign bus_b.dc_ready = dp_en && (dly_b == 1);
   assign bus_a.pt_ready = pt_ready;
   assign bus_b.pt_ready = pt_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push_pts(input int which, input int n);
      pt_t p;
      for (int i = 0; i < n; i++) begin
         p.x    = (which == 0) ? ax_tab[i] : bx_tab[i];
         p.z    = z_tab[i];
         p.last = (i == 5);
         if (which == 0) q_a.push_back(p);
         else q_b.push_back(p);
      end
   endtask

   // Monitor: every accepted point is compared against the head of its queue.
   always @(negedge clk) begin
      pt_t p;
      if (!reset && bus_a.pt_valid && bus_a.pt_ready) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_point", {bus_a.x_f, bus_a.z_f}, 32'hFFFF_FFFF);
         end else begin
            p = q_a.pop_front();
            check("a_pt_x", bus_a.x_f, p.x);
            check("a_pt_z", bus_a.z_f, p.z);
            check("a_pt_last", bus_a.pt_last, p.last);
         end
      end
      if (!reset && bus_b.pt_valid && bus_b.pt_ready) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_point", {bus_b.x_f, bus_b.z_f}, 32'hFFFF_FFFF);
         end else begin
            p = q_b.pop_front();
            check("b_pt_x", bus_b.x_f, p.x);
            check("b_pt_z", bus_b.z_f, p.z);
            check("b_pt_last", bus_b.pt_last, p.last);
         end
      end
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
   end

   task automatic start_a();
      @(posedge clk); #1 scan_start = 1'b1;
      @(posedge clk); #1 scan_start = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus_a.pt_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, bus_a.pt_valid, 1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done_a && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(name, done_a, 1);
   endtask

   task automatic check_idle_a(input string pfx);
      check({pfx, "_dc_clear"}, bus_a.dc_clear, 0);
      check({pfx, "_dc_start"}, bus_a.dc_start, 0);
      check({pfx, "_pt_valid"}, bus_a.pt_valid, 0);
      check({pfx, "_pt_last"}, bus_a.pt_last, 0);
      check({pfx, "_busy"}, busy_a, 0);
      check({pfx, "_done"}, done_a, 0);
      check({pfx, "_tmo"}, tmo_a, 0);
      check({pfx, "_x"}, bus_a.x_f, 16'h0000);
      check({pfx, "_z"}, bus_a.z_f, 16'h0100);
      check({pfx, "_pc"}, pc_a, 0);
   endtask

   initial begin
      int n;
      reset = 1'b1; scan_start = 1'b0; scan_start_b = 1'b0;
      scan_abort = 1'b0; pt_ready = 1'b1; dp_en = 1'b1;

      // Reset values
      @(negedge clk);
      check("rst_dc_clear_during", bus_a.dc_clear, 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle_a("rst");
      check("rst_b_x", bus_b.x_f, 16'hFFF0);

      // Full frame on both DUTs, with a stray scan_start mid-frame on A
      push_pts(0, 6);
      push_pts(1, 6);
      @(posedge clk); #1 scan_start = 1'b1; scan_start_b = 1'b1;
      @(posedge clk); #1 scan_start = 1'b0; scan_start_b = 1'b0;
      @(negedge clk);
      check("t1_busy", busy_a, 1);
      check("t1_dc_clear", bus_a.dc_clear, 1);
      repeat (10) @(posedge clk);
      #1 scan_start = 1'b1;
      @(posedge clk); #1 scan_start = 1'b0;
      wait_done("t1_done_seen");
      check("t1_finish_clear", bus_a.dc_clear, 1);
      @(negedge clk);
      check("t1_busy_end", busy_a, 0);
      check("t1_done_end", done_a, 0);
      check("t1_pc", pc_a, 6);
      check("t1_done_cnt", done_cnt_a, 1);
      check("t1_x_hold", bus_a.x_f, 16'h0010);
      check("t1_z_hold", bus_a.z_f, 16'h0110);
      check("t1_q_empty", q_a.size(), 0);
      check("t1_b_pc", pc_b, 6);
      check("t1_b_done_cnt", done_cnt_b, 1);
      check("t1_b_x_wrap", bus_b.x_f, 16'h0010);
      check("t1_b_q_empty", q_b.size(), 0);

      // Backpressure stall of 10 cycles on point 2
      pt_ready = 1'b0;
      push_pts(0, 6);
      start_a();
      wait_valid("t2_p1_valid");
      @(posedge clk); #1 pt_ready = 1'b1;
      @(posedge clk); #1 pt_ready = 1'b0;
      wait_valid("t2_p2_valid");
      for (int i = 0; i < 10; i++) begin
         check("t2_stall_valid", bus_a.pt_valid, 1);
         check("t2_stall_x", bus_a.x_f, 16'h0000);
         check("t2_stall_z", bus_a.z_f, 16'h0108);
         check("t2_stall_no_start", bus_a.dc_start, 0);
         if (i < 9) @(negedge clk);
      end
      @(posedge clk); #1 pt_ready = 1'b1;
      wait_done("t2_done_seen");
      @(negedge clk);
      check("t2_done_cnt", done_cnt_a, 2);
      check("t2_pc", pc_a, 6);
      check("t2_q_empty", q_a.size(), 0);

      // Datapath never ready: timeout 16 cycles after dc_start
      dp_en = 1'b0;
      start_a();
      n = 0;
      while (!bus_a.dc_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t3_dc_start_seen", bus_a.dc_start, 1);
      repeat (15) @(negedge clk);
      check("t3_tmo_early", tmo_a, 0);
      check("t3_busy_early", busy_a, 1);
      @(negedge clk);
      check("t3_tmo", tmo_a, 1);
      check("t3_dc_clear", bus_a.dc_clear, 1);
      check("t3_busy", busy_a, 0);
      check("t3_done", done_a, 0);
      @(negedge clk);
      check("t3_dc_clear_end", bus_a.dc_clear, 0);
      check("t3_tmo_sticky", tmo_a, 1);
      check("t3_done_cnt", done_cnt_a, 2);
      dp_en = 1'b1;

      // Abort in WAIT_RDY of point 3, then restart
      push_pts(0, 2);
      start_a();
      @(negedge clk);
      check("t4_tmo_cleared", tmo_a, 0);
      n = 0;
      for (int k = 0; k < 200 && n < 3; k++) begin
         @(negedge clk);
         if (bus_a.dc_start) n++;
      end
      check("t4_third_start", n, 3);
      @(posedge clk); #1 scan_abort = 1'b1;
      @(posedge clk); #1 scan_abort = 1'b0;
      @(negedge clk);
      check("t4_busy", busy_a, 0);
      check("t4_dc_clear", bus_a.dc_clear, 1);
      check("t4_pt_valid", bus_a.pt_valid, 0);
      check("t4_done", done_a, 0);
      @(negedge clk);
      check("t4_dc_clear_end", bus_a.dc_clear, 0);
      check("t4_q_empty", q_a.size(), 0);
      check("t4_done_cnt", done_cnt_a, 2);
      repeat (6) @(posedge clk);
      push_pts(0, 6);
      start_a();
      @(negedge clk);
      check("t4_restart_x", bus_a.x_f, 16'h0000);
      check("t4_restart_z", bus_a.z_f, 16'h0100);
      wait_done("t4_done_seen");
      @(negedge clk);
      check("t4_done_cnt_end", done_cnt_a, 3);
      check("t4_pc", pc_a, 6);
      check("t4_q_empty_end", q_a.size(), 0);

      // Reset asserted mid-EMIT
      pt_ready = 1'b0;
      start_a();
      wait_valid("t5_valid");
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("t5_dc_clear_rst", bus_a.dc_clear, 1);
      @(negedge clk);
      check("t5_busy_rst", busy_a, 0);
      check("t5_valid_rst", bus_a.pt_valid, 0);
      @(posedge clk); #1 reset = 1'b0;
      pt_ready = 1'b1;
      @(negedge clk);
      check_idle_a("t5");
      check("t5_done_cnt", done_cnt_a, 3);
      check("t5_b_busy", busy_b, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
